game_round_controller: RTL and testbench
========================================

# game_round_controller

Session-level controller above the game master FSM. It sequences a multi-round game: it gates the master FSM, counts wins and losses, keeps score and lives, and raises the difficulty level that configures the target sprite speed. It sits between the key/debounce logic and the game master FSM, and feeds the score/level display and the target `dxy` selection.

## Interface
- `MAX_LIVES`, 3: lives at game start; range 1..3.
- `HITS_PER_LEVEL`, 4: wins needed per level increment; range 1..15.
- `MAX_LEVEL`, 7: level saturation value; range 0..7.
- `SCORE_WIDTH`, 8: score counter width.

- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `new_game`  in  1  one-cycle pulse from debounced key; starts or restarts a session.
- `round_end`  in  1  one-cycle pulse from the master FSM marking the end of a round (its end-of-game timer start).
- `round_won`  in  1  master FSM `game_won` level; sampled only in the cycle `round_end` is high.
- `master_enable`  out  1  high while rounds may run; the master FSM holds in START while low.
- `level`  out  3  current difficulty, 0..`MAX_LEVEL`.
- `target_speed`  out  4  `level + 1`; selects the target `dxy` magnitude.
- `score`  out  `SCORE_WIDTH`  rounds won this session; saturating.
- `lives`  out  2  remaining lives.
- `level_up`  out  1  one-cycle pulse when `level` increments.
- `game_over`  out  1  high in GAME_OVER.

## Operation
- States: IDLE, PLAY, UPDATE, GAME_OVER; binary encoded.
- All outputs are registered.
- Reset values:
  - state IDLE
  - `master_enable`=0, `level`=0, `target_speed`=1, `score`=0
  - `lives`=`MAX_LIVES`, `level_up`=0, `game_over`=0
  - internal hit counter=0
- IDLE:
  - `new_game` -> PLAY and `master_enable`=1.
  - All other inputs are ignored.
- PLAY:
  - `round_end` -> UPDATE; capture `round_won` into a `won_q` register.
  - `new_game` is ignored.
  - If `round_end` and `new_game` arrive in the same cycle, `round_end` wins.
- UPDATE, one cycle, using `won_q`:
  - Win:
    - `score` += 1, saturating at all-ones.
    - If the hit counter equals `HITS_PER_LEVEL`-1, clear it. Then, if `level` < `MAX_LEVEL`, increment `level` and pulse `level_up`. At `MAX_LEVEL`, there is no increment and no pulse.
    - Otherwise, increment the hit counter.
    - Next state PLAY.
  - Loss:
    - `lives` -= 1. If the new value is 0 -> GAME_OVER, `master_enable`=0, `game_over`=1. Otherwise -> PLAY.
    - A loss does not change the hit counter or `level`.
  - `round_end` and `new_game` are ignored in UPDATE.
- GAME_OVER:
  - `score`, `level` and `lives` (=0) hold their values for display.
  - `new_game` -> PLAY with `score`=0, `level`=0, hit counter=0, `lives`=`MAX_LIVES`, `game_over`=0, `master_enable`=1, all in the same edge.
  - `round_end` is ignored.
- `target_speed` always equals `level`+1 and updates on the same edge as `level`.
- Reset asserted mid-operation forces all reset values immediately (asynchronous), regardless of state.

## Timing
- `new_game` high at edge N (in IDLE or GAME_OVER): `master_enable`=1 and counters initialised after edge N.
- `round_end` high at edge N in PLAY: state=UPDATE after N.
- Updated `score`/`lives`/`level`/`level_up`/`game_over` are visible after edge N+1; state is PLAY or GAME_OVER after N+1.
- `level_up` is high for exactly the cycle after N+1 and low otherwise.
- `master_enable` falls after edge N+1 on the final loss.
- Input contract: `round_end` pulses are at least 2 cycles apart. A pulse landing in UPDATE is dropped.

## Test plan
- Reset, then `new_game`:
  - After reset: outputs `master_enable`=0, `lives`=3, `score`=0, `level`=0, `target_speed`=1.
  - After the `new_game` edge: `master_enable`=1.
- 4 wins (`round_end` with `round_won`=1, 5 cycles apart):
  - `score` steps 1..4.
  - `level` goes 0->1 two cycles after the 4th `round_end`.
  - `level_up` pulses once, for one cycle; `target_speed`=2.
- 3 losses:
  - `lives` goes 3->2->1->0.
  - After the 3rd: `game_over`=1, `master_enable`=0, `score` is held.
  - Further `round_end` pulses change nothing.
- Level saturation:
  - 32 wins -> `level`=7, `target_speed`=8, 7 `level_up` pulses total.
  - 4 more wins -> `level` stays 7, no pulse, `score`=36.
- Score saturation with `SCORE_WIDTH`=3: 9 wins -> `score` stays at 7.
- Restart and corner cases:
  - `new_game` in GAME_OVER restores `lives`=3, `score`=0, `level`=0 in one edge.
  - `new_game` coincident with `round_end` in PLAY: the round is counted and there is no restart.
  - `reset` asserted during UPDATE: all outputs return to reset values without waiting for a clock.

Source files
------------

// File: rtl/game_round_controller.sv
// Session controller above the game master FSM: gates rounds, tracks score, lives and
// difficulty level, and derives the target sprite speed from the level.
module game_round_controller #(
  parameter int unsigned MAX_LIVES      = 3,
  parameter int unsigned HITS_PER_LEVEL = 4,
  parameter int unsigned MAX_LEVEL      = 7,
  parameter int unsigned SCORE_WIDTH    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   new_game,
  input  logic                   round_end,
  input  logic                   round_won,
  output logic                   master_enable,
  output logic [2:0]             level,
  output logic [3:0]             target_speed,
  output logic [SCORE_WIDTH-1:0] score,
  output logic [1:0]             lives,
  output logic                   level_up,
  output logic                   game_over
);

  localparam logic [1:0] LIVES_INIT = 2'(MAX_LIVES);
  localparam logic [3:0] HIT_LAST   = 4'(HITS_PER_LEVEL - 1);
  localparam logic [2:0] LEVEL_MAX  = 3'(MAX_LEVEL);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StPlay     = 2'd1,
    StUpdate   = 2'd2,
    StGameOver = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic                   won_q, won_d;
  logic [3:0]             hit_q, hit_d;
  logic [2:0]             level_q, level_d;
  logic [3:0]             speed_q, speed_d;
  logic [SCORE_WIDTH-1:0] score_q, score_d;
  logic [1:0]             lives_q, lives_d;
  logic                   enable_q, enable_d;
  logic                   level_up_q, level_up_d;
  logic                   over_q, over_d;

  always_comb begin
    state_d    = state_q;
    won_d      = won_q;
    hit_d      = hit_q;
    level_d    = level_q;
    score_d    = score_q;
    lives_d    = lives_q;
    enable_d   = enable_q;
    over_d     = over_q;
    level_up_d = 1'b0;

    unique case (state_q)
      StIdle, StGameOver: begin
        // A new session reinitialises every counter on the same edge it enables rounds.
        if (new_game) begin
          state_d  = StPlay;
          enable_d = 1'b1;
          over_d   = 1'b0;
          score_d  = '0;
          level_d  = '0;
          hit_d    = '0;
          lives_d  = LIVES_INIT;
        end
      end
      StPlay: begin
        if (round_end) begin
          state_d = StUpdate;
          won_d   = round_won;
        end
      end
      StUpdate: begin
        if (won_q) begin
          state_d = StPlay;
          if (score_q != '1) begin
            score_d = score_q + 1'b1;
          end
          if (hit_q == HIT_LAST) begin
            hit_d = '0;
            if (level_q < LEVEL_MAX) begin
              level_d    = level_q + 3'd1;
              level_up_d = 1'b1;
            end
          end else begin
            hit_d = hit_q + 4'd1;
          end
        end else begin
          lives_d = lives_q - 2'd1;
          if (lives_q == 2'd1) begin
            state_d  = StGameOver;
            enable_d = 1'b0;
            over_d   = 1'b1;
          end else begin
            state_d = StPlay;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    speed_d = {1'b0, level_d} + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      won_q      <= 1'b0;
      hit_q      <= '0;
      level_q    <= '0;
      speed_q    <= 4'd1;
      score_q    <= '0;
      lives_q    <= LIVES_INIT;
      enable_q   <= 1'b0;
      level_up_q <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      won_q      <= won_d;
      hit_q      <= hit_d;
      level_q    <= level_d;
      speed_q    <= speed_d;
      score_q    <= score_d;
      lives_q    <= lives_d;
      enable_q   <= enable_d;
      level_up_q <= level_up_d;
      over_q     <= over_d;
    end
  end

  assign master_enable = enable_q;
  assign level         = level_q;
  assign target_speed  = speed_q;
  assign score         = score_q;
  assign lives         = lives_q;
  assign level_up      = level_up_q;
  assign game_over     = over_q;

endmodule

// File: tb/tb_game_round_controller.sv
// Bench for game_round_controller: directed sessions plus random rounds, checked against a
// count-based model (wins/losses per session) on an 8-bit and a 3-bit score instance.
module tb_game_round_controller;

  localparam int unsigned HPL  = 4;
  localparam int unsigned MAXL = 7;
  localparam int unsigned LIV  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       new_game;
  logic       round_end;
  logic       round_won;
  logic       master_enable, master_enable3;
  logic [2:0] level, level3;
  logic [3:0] target_speed, target_speed3;
  logic [7:0] score;
  logic [2:0] score3;
  logic [1:0] lives, lives3;
  logic       level_up, level_up3;
  logic       game_over, game_over3;

  game_round_controller dut (
    .clk           (clk),
    .reset         (reset),
    .new_game      (new_game),
    .round_end     (round_end),
    .round_won     (round_won),
    .master_enable (master_enable),
    .level         (level),
    .target_speed  (target_speed),
    .score         (score),
    .lives         (lives),
    .level_up      (level_up),
    .game_over     (game_over)
  );

  game_round_controller #(.SCORE_WIDTH(3)) dut3 (
    .clk           (clk),
    .reset         (reset),
    .new_game      (new_game),
    .round_end     (round_end),
    .round_won     (round_won),
    .master_enable (master_enable3),
    .level         (level3),
    .target_speed  (target_speed3),
    .score         (score3),
    .lives         (lives3),
    .level_up      (level_up3),
    .game_over     (game_over3)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int lu_count    = 0;

  always @(posedge clk) if (level_up === 1'b1) lu_count <= lu_count + 1;

  // Session model: everything follows from wins and losses since the last new_game.
  bit m_started;
  int m_wins;
  int m_losses;

  function automatic bit m_active();
    return m_started && (m_losses < LIV);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input bit exp_lu);
    int exp_level;
    exp_level = (m_wins / HPL > MAXL) ? MAXL : m_wins / HPL;
    chk({tag, ":enable"}, 32'(master_enable), 32'(m_active()));
    chk({tag, ":lives"}, 32'(lives), 32'(LIV - m_losses));
    chk({tag, ":score"}, 32'(score), 32'((m_wins > 255) ? 255 : m_wins));
    chk({tag, ":score3"}, 32'(score3), 32'((m_wins > 7) ? 7 : m_wins));
    chk({tag, ":level"}, 32'(level), 32'(exp_level));
    chk({tag, ":speed"}, 32'(target_speed), 32'(exp_level + 1));
    chk({tag, ":level_up"}, 32'(level_up), 32'(exp_lu));
    chk({tag, ":game_over"}, 32'(game_over), 32'(m_started && m_losses == LIV));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game(input string tag);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    if (!m_active()) begin
      m_started = 1'b1;
      m_wins    = 0;
      m_losses  = 0;
    end
    check_all(tag, 1'b0);
  endtask

  // One round_end pulse, five cycles per call; ng raises new_game on the same edge.
  task automatic do_round(input string tag, input bit won, input bit ng);
    bit exp_lu;
    bit restart;
    exp_lu    = 1'b0;
    restart   = ng && !m_active();
    round_end = 1'b1;
    round_won = won;
    new_game  = ng;
    tick();
    round_end = 1'b0;
    new_game  = 1'b0;
    round_won = $urandom_range(0, 1);
    chk({tag, ":lu_mid"}, 32'(level_up), 32'(0));
    tick();
    if (restart) begin
      m_started = 1'b1;
      m_wins    = 0;
      m_losses  = 0;
    end else if (m_active()) begin
      if (won) begin
        m_wins++;
        exp_lu = (m_wins % HPL == 0) && (m_wins / HPL <= MAXL);
      end else begin
        m_losses++;
      end
    end
    check_all(tag, exp_lu);
    tick();
    chk({tag, ":lu_after"}, 32'(level_up), 32'(0));
    tick();
    tick();
  endtask

  initial begin
    int base;
    reset     = 1'b1;
    new_game  = 1'b0;
    round_end = 1'b0;
    round_won = 1'b0;
    m_started = 1'b0;
    m_wins    = 0;
    m_losses  = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all("reset", 1'b0);

    // Rounds before new_game are ignored in IDLE.
    do_round("idle_round", 1'b1, 1'b0);
    start_game("start");

    base = lu_count;
    for (int i = 0; i < 4; i++) do_round("win4", 1'b1, 1'b0);
    chk("win4:lu_pulses", 32'(lu_count - base), 32'(1));

    for (int i = 0; i < 3; i++) do_round("loss", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) do_round("over_ignore", 1'($urandom_range(0, 1)), 1'b0);

    start_game("restart");
    base = lu_count;
    for (int i = 0; i < 36; i++) do_round("sat", 1'b1, 1'b0);
    chk("sat:lu_pulses", 32'(lu_count - base), 32'(7));

    do_round("ng_coincident", 1'b0, 1'b1);
    do_round("ng_coincident_win", 1'b1, 1'b1);

    for (int i = 0; i < 60; i++) begin
      if (!m_active() && $urandom_range(0, 2) == 0) start_game("rand_start");
      else do_round("rand", 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset landing in the UPDATE cycle.
    if (!m_active()) start_game("pre_reset");
    do_round("pre_reset_win", 1'b1, 1'b0);
    round_end = 1'b1;
    round_won = 1'b1;
    tick();
    round_end = 1'b0;
    reset     = 1'b1;
    #1;
    m_started = 1'b0;
    m_wins    = 0;
    m_losses  = 0;
    check_all("async_reset", 1'b0);
    tick();
    reset = 1'b0;
    tick();
    check_all("after_reset", 1'b0);
    start_game("post_reset");
    do_round("post_reset_win", 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish, expected finish before 2000000");
    $fatal(1, "timeout");
  end

endmodule
